// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one non-pipelined modular multiplier.
// Define MODEXP_CONSTTIME_EN for the constant-time flow: no leading-zero skip, SQ and MUL issued for every bit.
module modexp_ctrl #(
  parameter int N    = 256,
  parameter int E    = 256,
  parameter int LOGN = $clog2(N)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic [N-1:0]    base,
  input  logic [E-1:0]    exponent,
  input  logic [N-1:0]    r,
  input  logic [N-1:0]    rn,
  input  logic [N-1:0]    rm,
  input  logic [N-1:0]    rx1,
  input  logic [N-1:0]    rx2,
  input  logic [N-1:0]    rx3,
  input  logic [LOGN:0]   k,
  output logic            busy,
  output logic            done,
  output logic [N-1:0]    result,
  output logic            mul_reset,
  output logic [N-1:0]    mul_a,
  output logic [N-1:0]    mul_b,
  output logic [N-1:0]    mul_r,
  output logic [N-1:0]    mul_rn,
  output logic [N-1:0]    mul_rm,
  output logic [N-1:0]    mul_rx1,
  output logic [N-1:0]    mul_rx2,
  output logic [N-1:0]    mul_rx3,
  output logic [LOGN:0]   mul_k,
  input  logic [N-1:0]    mul_result,
  input  logic            mul_done
);

  localparam int IW = (E > 1) ? $clog2(E) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(E - 1);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);
  localparam logic [N-1:0]  ACC_ONE = N'(1);
  localparam logic          OP_SQ   = 1'b0;
  localparam logic          OP_MUL  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SCAN   = 3'd1,
    S_HOLD   = 3'd2,
    S_RUN    = 3'd3,
    S_NEXT   = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [E-1:0]  r_exp;
  logic [N-1:0]  r_base;
  logic [N-1:0]  r_acc;
  logic [N-1:0]  w_acc_nx;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] w_idx_nx;
  logic          r_op;
  logic          w_op_nx;
  logic          r_busy;
  logic          w_busy_nx;
  logic          r_done;
  logic          w_done_nx;
  logic [N-1:0]  r_result;
  logic [N-1:0]  w_result_nx;
  logic          r_mul_reset;
  logic          w_mul_reset_nx;
  logic [N-1:0]  r_mul_a;
  logic [N-1:0]  w_mul_a_nx;
  logic [N-1:0]  r_mul_b;
  logic [N-1:0]  w_mul_b_nx;
  logic [N-1:0]  r_r;
  logic [N-1:0]  r_rn;
  logic [N-1:0]  r_rm;
  logic [N-1:0]  r_rx1;
  logic [N-1:0]  r_rx2;
  logic [N-1:0]  r_rx3;
  logic [LOGN:0] r_k;
  logic          w_latch;
  logic          w_bit;
  logic          w_idx_zero;

  assign w_bit      = r_exp[r_idx];
  assign w_idx_zero = (r_idx == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_acc_nx       = r_acc;
    w_idx_nx       = r_idx;
    w_op_nx        = r_op;
    w_busy_nx      = r_busy;
    w_done_nx      = 1'b0;
    w_result_nx    = r_result;
    w_mul_reset_nx = r_mul_reset;
    w_mul_a_nx     = r_mul_a;
    w_mul_b_nx     = r_mul_b;
    w_latch        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_mul_reset_nx = 1'b1;
        if (start) begin
          w_latch    = 1'b1;
          w_busy_nx  = 1'b1;
          w_idx_nx   = IDX_TOP;
          w_state_nx = S_SCAN;
        end
      end
      S_SCAN: begin
`ifdef MODEXP_CONSTTIME_EN
        w_acc_nx   = ACC_ONE;
        w_idx_nx   = IDX_TOP;
        w_op_nx    = OP_SQ;
        w_state_nx = S_HOLD;
`else
        // Skip leading zeros; the first set bit seeds acc with base directly.
        if (w_bit) begin
          w_acc_nx = r_base;
          if (w_idx_zero) begin
            w_state_nx = S_FINISH;
          end else begin
            w_idx_nx   = r_idx - IDX_ONE;
            w_op_nx    = OP_SQ;
            w_state_nx = S_HOLD;
          end
        end else if (w_idx_zero) begin
          w_acc_nx   = ACC_ONE;
          w_state_nx = S_FINISH;
        end else begin
          w_idx_nx = r_idx - IDX_ONE;
        end
`endif
      end
      S_HOLD: begin
        // Operands and the reset release land on the same edge, so the
        // multiplier's first unreset sample already sees them.
        w_mul_a_nx     = r_acc;
        w_mul_b_nx     = (r_op == OP_MUL) ? r_base : r_acc;
        w_mul_reset_nx = 1'b0;
        w_state_nx     = S_RUN;
      end
      S_RUN: begin
        if (mul_done) begin
`ifdef MODEXP_CONSTTIME_EN
          if (!((r_op == OP_MUL) && !w_bit)) begin
            w_acc_nx = mul_result;
          end
`else
          w_acc_nx = mul_result;
`endif
          w_mul_reset_nx = 1'b1;
          w_state_nx     = S_NEXT;
        end
      end
      S_NEXT: begin
`ifdef MODEXP_CONSTTIME_EN
        if (r_op == OP_SQ) begin
`else
        if ((r_op == OP_SQ) && w_bit) begin
`endif
          w_op_nx    = OP_MUL;
          w_state_nx = S_HOLD;
        end else if (w_idx_zero) begin
          w_state_nx = S_FINISH;
        end else begin
          w_idx_nx   = r_idx - IDX_ONE;
          w_op_nx    = OP_SQ;
          w_state_nx = S_HOLD;
        end
      end
      S_FINISH: begin
        w_result_nx = r_acc;
        w_done_nx   = 1'b1;
        w_busy_nx   = 1'b0;
        w_state_nx  = S_IDLE;
      end
      default: begin
        w_mul_reset_nx = 1'b1;
        w_busy_nx      = 1'b0;
        w_state_nx     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_exp       <= '0;
      r_base      <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_op        <= OP_SQ;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_mul_reset <= 1'b1;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_r         <= '0;
      r_rn        <= '0;
      r_rm        <= '0;
      r_rx1       <= '0;
      r_rx2       <= '0;
      r_rx3       <= '0;
      r_k         <= '0;
    end else begin
      r_acc       <= w_acc_nx;
      r_idx       <= w_idx_nx;
      r_op        <= w_op_nx;
      r_busy      <= w_busy_nx;
      r_done      <= w_done_nx;
      r_result    <= w_result_nx;
      r_mul_reset <= w_mul_reset_nx;
      r_mul_a     <= w_mul_a_nx;
      r_mul_b     <= w_mul_b_nx;
      if (w_latch) begin
        r_exp  <= exponent;
        r_base <= base;
        r_r    <= r;
        r_rn   <= rn;
        r_rm   <= rm;
        r_rx1  <= rx1;
        r_rx2  <= rx2;
        r_rx3  <= rx3;
        r_k    <= k;
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign mul_reset = r_mul_reset;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign mul_r     = r_r;
  assign mul_rn    = r_rn;
  assign mul_rm    = r_rm;
  assign mul_rx1   = r_rx1;
  assign mul_rx2   = r_rx2;
  assign mul_rx3   = r_rx3;
  assign mul_k     = r_k;

endmodule
